// File: rtl/sar_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the parametrised SAR sequencer.
package sar_ctrl_pkg;

   typedef logic [1:0] sar_state_t;

   localparam sar_state_t ST_IDLE    = 2'd0;
   localparam sar_state_t ST_SAMPLE  = 2'd1;
   localparam sar_state_t ST_CONVERT = 2'd2;
   localparam sar_state_t ST_DONE    = 2'd3;

   // Bit-index width: must hold NBITS-1, never narrower than one bit.
   function automatic int idx_w(input int nbits);
      return (nbits <= 2) ? 1 : $clog2(nbits);
   endfunction

endpackage

// File: rtl/sar_onehot_dec.sv
// Bit index + enable to one-hot small-FSM enable vector (combinational).
module sar_onehot_dec #(
   parameter int NBITS = 6,
   parameter int IW    = 3
) (
   input  logic [IW-1:0]    idx_i,
   input  logic             en_i,
   output logic [NBITS-2:0] onehot_o
);

   for (genvar g = 0; g < NBITS-1; g++) begin : g_bit
      assign onehot_o[g] = en_i && (idx_i == IW'(g));
   end

endmodule

// File: rtl/sar_ctrl_param.sv
// SAR ADC top-level sequencer: IDLE -> SAMPLE -> CONVERT (NBITS cycles) -> DONE.
// Optional result-overrun detection is built when SAR_CTRL_OVERRUN_EN is defined.
module sar_ctrl_param
   import sar_ctrl_pkg::*;
#(
   parameter int NBITS         = 6,
   parameter int SAMPLE_CYCLES = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic             CONT,
   input  logic             VCOMP,
`ifdef SAR_CTRL_OVERRUN_EN
   input  logic             RESULT_ACK,
   output logic             OVERRUN,
`endif
   output logic [NBITS-2:0] OUTEN,
   output logic             SAR_RESET,
   output logic             BUSY,
   output logic             DATA_VALID,
   output logic [NBITS-1:0] RESULT,
   output logic             LSBOUT
);

   localparam int IW = idx_w(NBITS);

   sar_state_t       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IW-1:0]    k_q, k_d;
   logic [NBITS-1:0] shift_q, shift_d;
   logic [NBITS-1:0] result_q, result_d;
   logic             lsb_q, lsb_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      k_d      = k_q;
      shift_d  = shift_q;
      result_d = result_q;
      lsb_d    = lsb_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_SAMPLE;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         ST_SAMPLE: begin
            if (cnt_q == 4'(SAMPLE_CYCLES-1)) begin
               state_d = ST_CONVERT;
               cnt_d   = '0;
               k_d     = IW'(NBITS-1);
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_CONVERT: begin
            shift_d = {shift_q[NBITS-2:0], VCOMP};
            if (k_q == '0) begin
               result_d = {shift_q[NBITS-2:0], VCOMP};
               lsb_d    = VCOMP;
               state_d  = ST_DONE;
            end else begin
               k_d = k_q - 1'b1;
            end
         end
         ST_DONE: begin
            // Clearing the shift register here keeps back-to-back codes independent.
            if (CONT) begin
               state_d = ST_SAMPLE;
               cnt_d   = '0;
               shift_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         k_q      <= IW'(NBITS-1);
         shift_q  <= '0;
         result_q <= '0;
         lsb_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         k_q      <= k_d;
         shift_q  <= shift_d;
         result_q <= result_d;
         lsb_q    <= lsb_d;
      end
   end

   assign SAR_RESET  = (state_q == ST_IDLE) || (state_q == ST_SAMPLE);
   assign BUSY       = (state_q != ST_IDLE);
   assign DATA_VALID = (state_q == ST_DONE);
   assign RESULT     = result_q;
   assign LSBOUT     = lsb_q;

   // The LSB decision cycle (k = 0) drives no small FSM.
   sar_onehot_dec #(.NBITS(NBITS), .IW(IW)) u_dec (
      .idx_i    (k_q - 1'b1),
      .en_i     ((state_q == ST_CONVERT) && (k_q != '0)),
      .onehot_o (OUTEN)
   );

`ifdef SAR_CTRL_OVERRUN_EN
   logic pend_q, pend_d;
   logic ovr_q, ovr_d;

   always_comb begin
      pend_d = pend_q;
      if (DATA_VALID)      pend_d = 1'b1;
      else if (RESULT_ACK) pend_d = 1'b0;
      ovr_d = ovr_q | (DATA_VALID & pend_q & ~RESULT_ACK);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pend_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
      end
   end

   assign OVERRUN = ovr_q;
`endif

endmodule

// File: doc/sar_ctrl_param.md
Name: sar_ctrl_param

Overview:
- Parametrised successor to the fixed 6-bit SAR top-level sequencer. Generalised to NBITS resolution and a programmable sample window.
- Adds a START/BUSY/DATA_VALID handshake, a continuous-conversion mode, an internal result register and a registered LSB capture, which replaces the old transparent LSB path.
- Sits between the comparator (VCOMP) and the per-bit small FSMs / capacitor-DAC switch drivers in the SAR ADC.

Parameters:
- NBITS, 6, conversion resolution; legal range 2..16.
- SAMPLE_CYCLES, 1, number of cycles SAR_RESET is held high in SAMPLE; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  request one conversion; sampled only in IDLE.
- CONT  input  1  continuous mode: when high, DONE goes straight back to SAMPLE.
- VCOMP  input  1  comparator output for the bit under test; 1 = keep bit.
- OUTEN  output  NBITS-1  one-hot enable to the small FSMs; OUTEN[NBITS-2] corresponds to the MSB.
- SAR_RESET  output  1  resets the small FSMs and the DAC; high during SAMPLE.
- BUSY  output  1  high in SAMPLE, CONVERT and DONE.
- DATA_VALID  output  1  one-cycle pulse in DONE.
- RESULT  output  NBITS  last completed code; holds until the next DONE.
- LSBOUT  output  1  registered LSB (equals RESULT[0]).

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, sample counter = 0, bit index = NBITS-1.
  - OUTEN = 0, SAR_RESET = 1, BUSY = 0, DATA_VALID = 0, RESULT = 0, LSBOUT = 0.
- State IDLE:
  - Outputs: SAR_RESET = 1, OUTEN = 0.
  - START = 1 → SAMPLE next cycle.
- State SAMPLE:
  - Outputs: SAR_RESET = 1, OUTEN = 0.
  - Counter runs 0..SAMPLE_CYCLES-1, then → CONVERT with bit index k = NBITS-1.
- State CONVERT (exactly NBITS cycles, k = NBITS-1 down to 0):
  - SAR_RESET = 0.
  - For k ≥ 1: OUTEN = one-hot bit k-1. For k = 0: OUTEN = 0.
  - At each edge, VCOMP is shifted into the shift register (MSB first).
  - At the k = 0 edge: RESULT ← full code, LSBOUT ← VCOMP, then → DONE.
- State DONE (one cycle):
  - DATA_VALID = 1, OUTEN = 0, SAR_RESET = 0.
  - If CONT = 1 → SAMPLE; else → IDLE.
- All outputs except RESULT and LSBOUT are Moore decodes of registered state; no output depends combinationally on inputs.
- Latency: START high at edge E → DATA_VALID high in cycle E+SAMPLE_CYCLES+NBITS+1.
- Continuous throughput: one result every SAMPLE_CYCLES+NBITS+1 cycles.
- Boundary conditions:
  - START while BUSY: ignored, not queued.
  - START and CONT both high in IDLE: begins a conversion; CONT is evaluated only in DONE.
  - CONT dropped mid-conversion: the current conversion completes, then the block returns to IDLE.
  - RESET mid-conversion: aborts immediately to reset values. The partial code is discarded and RESULT clears to 0.
  - The shift register clears on SAMPLE entry, so a stale partial code never leaks into RESULT.
  - Illegal state encodings → IDLE.

Optional Feature:
- Macro SAR_CTRL_OVERRUN_EN.
- When defined, adds two ports:
  - input RESULT_ACK (1 bit).
  - output OVERRUN (1 bit, reset 0).
- An internal pending flag sets on DATA_VALID and clears on RESULT_ACK.
- If DATA_VALID fires while pending = 1 and RESULT_ACK is not high in that cycle, OVERRUN sets sticky. OVERRUN clears only on RESET.
- ACK and DATA_VALID in the same cycle: pending stays 1 and no overrun.
- When not defined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Package sar_ctrl_pkg holds:
  - state typedef (IDLE, SAMPLE, CONVERT, DONE, 2-bit encoding);
  - the state encoding constants;
  - a function that computes the bit-index width, clog2(NBITS).
- One sub-module, sar_onehot_dec: bit index plus enable → NBITS-1 one-hot OUTEN. It is purely combinational and reused by the small-FSM bank.

Test Plan:
- NBITS=6, SAMPLE_CYCLES=1. START pulse; VCOMP = 1,0,1,1,0,1 over CONVERT → RESULT = 6'b101101, LSBOUT = 1, DATA_VALID exactly in cycle 8 after the START edge. OUTEN sequence is 10000, 01000, 00100, 00010, 00001, 00000.
- SAMPLE_CYCLES=3, NBITS=8, VCOMP constant 1 → SAR_RESET high for 3 cycles after IDLE exit, RESULT = 8'hFF, DATA_VALID at cycle 12.
- CONT=1 held, alternating code patterns → DATA_VALID every 8 cycles (NBITS=6, SAMPLE_CYCLES=1), each RESULT correct. Drop CONT mid-conversion → one more result, then IDLE with BUSY = 0.
- RESET asserted during bit 3 of a conversion → all outputs at reset values immediately (asynchronous). The next START yields a correct fresh code with no residue.
- START pulsed during CONVERT → ignored, exactly one DATA_VALID. With SAR_CTRL_OVERRUN_EN and CONT=1 and no ACK → OVERRUN = 1 after the second DATA_VALID. With ACK given → OVERRUN stays 0.
